fifo_frame_assembler: RTL

Single-clock consumer on the read side of the on-chip FIFO. It pops data words through the FIFO read port and packs FRAMEBYTES consecutive words into one wide frame. It presents that frame on a valid/ready handshake to the downstream frame handler. A partial frame is discarded if the FIFO stays empty for longer than a programmable timeout, so one lost word cannot misalign every following frame.

---
 rtl/fifo_frame_assembler.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_frame_assembler.sv
// Packs FRAMEBYTES consecutive FIFO words into one wide frame that is offered on a valid/ready handshake.
// A partial frame is discarded after TIMEOUT idle cycles so that a lost word cannot misalign later frames.
module fifo_frame_assembler #(
  parameter int    DATASIZE    = 8,
  parameter int    FRAMEBYTES  = 10,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    TIMEOUT     = 255
) (
  input  logic                           rclk,
  input  logic                           rreset,
  input  logic                           rempty,
  input  logic [DATASIZE-1:0]            rdata,
  output logic                           rclken,
  output logic [DATASIZE*FRAMEBYTES-1:0] frame_data,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic                           drop_err,
  output logic [15:0]                    frame_cnt
);

  localparam bit FT = (FALLTHROUGH == "TRUE");
  localparam int CW = $clog2(FRAMEBYTES + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FB_C    = CW'(FRAMEBYTES);
  localparam logic [CW-1:0] FB_LAST = CW'(FRAMEBYTES - 1);
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t        state_q;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] captured_q;
  logic [IW-1:0] idle_q;
  logic          pending_q;
  logic          valid_q;
  logic          drop_q;
  logic [15:0]   cnt_q;
  logic          capture;

  // rclken is forced low while reset is held so no word is popped and lost.
  assign rclken  = !rreset && (state_q == COLLECT) && !rempty && (issued_q < FB_C);
  assign capture = FT ? rclken : pending_q;

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      state_q    <= COLLECT;
      issued_q   <= '0;
      captured_q <= '0;
      idle_q     <= '0;
      pending_q  <= 1'b0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      drop_q    <= 1'b0;
      pending_q <= !FT && rclken;
      case (state_q)
        COLLECT: begin
          if (rclken) begin
            issued_q <= issued_q + CW'(1);
          end
          // A pop always beats an expiring timeout; a pending capture freezes the idle count.
          if (rclken || (captured_q == '0)) begin
            idle_q <= '0;
          end else if (!pending_q && (TIMEOUT != 0)) begin
            if (idle_q == TO_LAST) begin
              issued_q   <= '0;
              captured_q <= '0;
              idle_q     <= '0;
              drop_q     <= 1'b1;
            end else begin
              idle_q <= idle_q + IW'(1);
            end
          end
          if (capture) begin
            if (captured_q == FB_LAST) begin
              state_q    <= HOLD;
              valid_q    <= 1'b1;
              issued_q   <= '0;
              captured_q <= '0;
            end else begin
              captured_q <= captured_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            state_q <= COLLECT;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  // Slots are only written by captures; stale slots are never offered because valid needs a full frame.
  for (genvar gi = 0; gi < FRAMEBYTES; gi++) begin : g_slot
    logic [DATASIZE-1:0] slot_q;
    always_ff @(posedge rclk or posedge rreset) begin
      if (rreset) begin
        slot_q <= '0;
      end else if ((state_q == COLLECT) && capture && (captured_q == CW'(gi))) begin
        slot_q <= rdata;
      end
    end
    assign frame_data[gi*DATASIZE +: DATASIZE] = slot_q;
  end

  assign frame_valid = valid_q;
  assign drop_err    = drop_q;
  assign frame_cnt   = cnt_q;

endmodule
